// File: rtl/inta_sequencer.sv
// 8259A INTA handshake: raises INT, runs the two-pulse acknowledge, owns the ISR
// and applies OCW2 end-of-interrupt commands.
module inta_sequencer #(
  parameter int unsigned VECTOR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                INT_request,
  input  logic [2:0]          serviced_interrupt_index,
  input  logic [2:0]          zeroLevelPriorityBit,
  input  logic                INTA_n,
  input  logic [4:0]          vector_base,
  input  logic                AEOI,
  input  logic                eoi_valid,
  input  logic [7:0]          OCW2,
  output logic                INT,
  output logic                INT_requestAck,
  output logic                freezing,
  output logic [7:0]          ISR_reg,
  output logic [2:0]          resetedISR_index,
  output logic                IRR_clear,
  output logic [2:0]          IRR_clear_index,
  output logic [VECTOR_W-1:0] data_out,
  output logic                data_out_en
);

  typedef enum logic [2:0] {IDLE, REQ, ACK1, GAP, ACK2} state_t;

  state_t state, state_d;

  logic s1, s2, s3;
  logic fall, rise;

  logic [2:0]          cur_idx, cur_idx_d;
  logic                int_d, ack_d, freezing_d, irr_clear_d, data_out_en_d;
  logic [2:0]          irr_clear_index_d, reseted_idx_d;
  logic [7:0]          isr_d;
  logic [VECTOR_W-1:0] data_out_d;

  logic [7:0] set_mask, aeoi_mask, eoi_mask;
  logic       eoi_hit;
  logic [2:0] eoi_idx, scan_pos;

  // INTA_n is asynchronous; s3 only keeps history for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= INTA_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      cur_idx          <= '0;
      INT              <= 1'b0;
      INT_requestAck   <= 1'b0;
      freezing         <= 1'b0;
      ISR_reg          <= '0;
      resetedISR_index <= '0;
      IRR_clear        <= 1'b0;
      IRR_clear_index  <= '0;
      data_out         <= '0;
      data_out_en      <= 1'b0;
    end else begin
      state            <= state_d;
      cur_idx          <= cur_idx_d;
      INT              <= int_d;
      INT_requestAck   <= ack_d;
      freezing         <= freezing_d;
      ISR_reg          <= isr_d;
      resetedISR_index <= reseted_idx_d;
      IRR_clear        <= irr_clear_d;
      IRR_clear_index  <= irr_clear_index_d;
      data_out         <= data_out_d;
      data_out_en      <= data_out_en_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (INT_request) state_d = REQ;
      REQ:     if (fall)        state_d = ACK1;
      ACK1:    if (rise)        state_d = GAP;
      GAP:     if (fall)        state_d = ACK2;
      ACK2:    if (rise)        state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // EOI target selection always looks at the pre-edge ISR value
  always_comb begin
    eoi_hit  = 1'b0;
    eoi_idx  = '0;
    scan_pos = '0;
    eoi_mask = '0;
    case (OCW2[7:5])
      3'b001, 3'b101: begin
        for (int unsigned i = 0; i < 8; i++) begin
          scan_pos = zeroLevelPriorityBit + 3'(i);
          if (!eoi_hit && ISR_reg[scan_pos]) begin
            eoi_hit = 1'b1;
            eoi_idx = scan_pos;
          end
        end
      end
      3'b011, 3'b111: begin
        eoi_idx = OCW2[2:0];
        eoi_hit = ISR_reg[OCW2[2:0]];
      end
      default: ;
    endcase
    if (!eoi_valid)
      eoi_hit = 1'b0;
    if (eoi_hit)
      eoi_mask = 8'h01 << eoi_idx;
  end

  always_comb begin
    cur_idx_d         = cur_idx;
    int_d             = INT;
    ack_d             = 1'b0;
    freezing_d        = freezing;
    irr_clear_d       = 1'b0;
    irr_clear_index_d = IRR_clear_index;
    data_out_d        = data_out;
    data_out_en_d     = data_out_en;
    reseted_idx_d     = resetedISR_index;
    set_mask          = '0;
    aeoi_mask         = '0;

    case (state)
      IDLE: begin
        if (INT_request) begin
          cur_idx_d = serviced_interrupt_index;
          int_d     = 1'b1;
        end
      end
      REQ: begin
        if (fall) begin
          int_d             = 1'b0;
          freezing_d        = 1'b1;
          set_mask          = 8'h01 << cur_idx;
          irr_clear_d       = 1'b1;
          irr_clear_index_d = cur_idx;
          ack_d             = 1'b1;
        end
      end
      GAP: begin
        if (fall) begin
          data_out_d    = VECTOR_W'({vector_base, cur_idx});
          data_out_en_d = 1'b1;
        end
      end
      ACK2: begin
        if (rise) begin
          data_out_en_d = 1'b0;
          freezing_d    = 1'b0;
          if (AEOI) begin
            aeoi_mask     = 8'h01 << cur_idx;
            reseted_idx_d = cur_idx;
          end
        end
      end
      default: ;
    endcase

    // EOI index overrides the AEOI index; a same-bit set beats any clear
    if (eoi_hit)
      reseted_idx_d = eoi_idx;
    isr_d = (ISR_reg & ~eoi_mask & ~aeoi_mask) | set_mask;
  end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: per-cycle vector table for the INTA
// handshake plus hand-written EOI, collision and reset-in-GAP sequences.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       INT_request = 1'b0;
  logic [2:0] serviced_interrupt_index = '0;
  logic [2:0] zeroLevelPriorityBit = '0;
  logic       INTA_n = 1'b1;
  logic [4:0] vector_base = 5'h11;
  logic       AEOI = 1'b0;
  logic       eoi_valid = 1'b0;
  logic [7:0] OCW2 = '0;

  logic       INT, INT_requestAck, freezing, IRR_clear, data_out_en;
  logic [7:0] ISR_reg, data_out;
  logic [2:0] resetedISR_index, IRR_clear_index;

  logic [26:0] outs;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inta_sequencer #(.VECTOR_W(8)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .INT_request              (INT_request),
    .serviced_interrupt_index (serviced_interrupt_index),
    .zeroLevelPriorityBit     (zeroLevelPriorityBit),
    .INTA_n                   (INTA_n),
    .vector_base              (vector_base),
    .AEOI                     (AEOI),
    .eoi_valid                (eoi_valid),
    .OCW2                     (OCW2),
    .INT                      (INT),
    .INT_requestAck           (INT_requestAck),
    .freezing                 (freezing),
    .ISR_reg                  (ISR_reg),
    .resetedISR_index         (resetedISR_index),
    .IRR_clear                (IRR_clear),
    .IRR_clear_index          (IRR_clear_index),
    .data_out                 (data_out),
    .data_out_en              (data_out_en)
  );

  assign outs = {INT, INT_requestAck, freezing, ISR_reg, resetedISR_index,
                 IRR_clear, IRR_clear_index, data_out, data_out_en};

  typedef struct {
    logic        rst;
    logic        req;
    logic [2:0]  idx;
    logic        inta_n;
    logic        aeoi;
    logic        eoi_v;
    logic [7:0]  ocw2;
    logic [26:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [26:0] pk(input logic i, input logic a, input logic f,
                                     input logic [7:0] isr, input logic [2:0] ridx,
                                     input logic c, input logic [2:0] cidx,
                                     input logic [7:0] d, input logic de);
    return {i, a, f, isr, ridx, c, cidx, d, de};
  endfunction

  task automatic add(input logic rst, input logic req, input logic [2:0] idx,
                     input logic inta_n, input logic aeoi, input logic eoi_v,
                     input logic [7:0] ocw2, input logic [26:0] exp);
    vec_t v;
    v.rst = rst; v.req = req; v.idx = idx; v.inta_n = inta_n;
    v.aeoi = aeoi; v.eoi_v = eoi_v; v.ocw2 = ocw2; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [26:0] exp);
    vectors++;
    if (outs !== exp) begin
      miscompares++;
      $display("FAIL %s: outputs got %h expected %h", name, outs, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_ack(input logic [2:0] idx);
    INT_request = 1'b1;
    serviced_interrupt_index = idx;
    step();
    INT_request = 1'b0;
    for (int p = 0; p < 4; p++) begin
      INTA_n = (p % 2 == 1);
      repeat (3) step();
    end
  endtask

  task automatic do_eoi(input logic [7:0] ocw2);
    OCW2 = ocw2;
    eoi_valid = 1'b1;
    step();
    eoi_valid = 1'b0;
  endtask

  initial begin
    // rst req idx inta aeoi eoiv ocw2 | INT ack frz ISR ridx iclr iidx dout den
    add(1, 0, 0, 1, 0, 0, 8'h00, pk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    add(0, 1, 3, 1, 0, 0, 8'h00, pk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    add(0, 0, 5, 0, 0, 0, 8'h00, pk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    add(0, 1, 5, 0, 0, 0, 8'h00, pk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0));
    add(0, 0, 5, 0, 0, 0, 8'h00, pk(0, 1, 1, 8'h08, 0, 1, 3, 8'h00, 0));
    repeat (3) add(0, 0, 0, 1, 0, 0, 8'h00, pk(0, 0, 1, 8'h08, 0, 0, 3, 8'h00, 0));
    repeat (2) add(0, 0, 0, 0, 0, 0, 8'h00, pk(0, 0, 1, 8'h08, 0, 0, 3, 8'h00, 0));
    add(0, 0, 0, 0, 0, 0, 8'h00, pk(0, 0, 1, 8'h08, 0, 0, 3, 8'h8B, 1));
    repeat (2) add(0, 0, 0, 1, 0, 0, 8'h00, pk(0, 0, 1, 8'h08, 0, 0, 3, 8'h8B, 1));
    add(0, 0, 0, 1, 0, 0, 8'h00, pk(0, 0, 0, 8'h08, 0, 0, 3, 8'h8B, 0));
    add(0, 0, 0, 1, 0, 1, 8'h63, pk(0, 0, 0, 8'h00, 3, 0, 3, 8'h8B, 0));
    add(0, 1, 6, 1, 1, 0, 8'h00, pk(1, 0, 0, 8'h00, 3, 0, 3, 8'h8B, 0));
    repeat (2) add(0, 0, 0, 0, 1, 0, 8'h00, pk(1, 0, 0, 8'h00, 3, 0, 3, 8'h8B, 0));
    add(0, 0, 0, 0, 1, 0, 8'h00, pk(0, 1, 1, 8'h40, 3, 1, 6, 8'h8B, 0));
    repeat (3) add(0, 0, 0, 1, 1, 0, 8'h00, pk(0, 0, 1, 8'h40, 3, 0, 6, 8'h8B, 0));
    repeat (2) add(0, 0, 0, 0, 1, 0, 8'h00, pk(0, 0, 1, 8'h40, 3, 0, 6, 8'h8B, 0));
    add(0, 0, 0, 0, 1, 0, 8'h00, pk(0, 0, 1, 8'h40, 3, 0, 6, 8'h8E, 1));
    repeat (2) add(0, 0, 0, 1, 1, 0, 8'h00, pk(0, 0, 1, 8'h40, 3, 0, 6, 8'h8E, 1));
    add(0, 0, 0, 1, 1, 0, 8'h00, pk(0, 0, 0, 8'h00, 6, 0, 6, 8'h8E, 0));
    add(0, 0, 0, 1, 0, 0, 8'h00, pk(0, 0, 0, 8'h00, 6, 0, 6, 8'h8E, 0));

    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      INT_request = vecs[i].req;
      serviced_interrupt_index = vecs[i].idx;
      INTA_n = vecs[i].inta_n;
      AEOI = vecs[i].aeoi;
      eoi_valid = vecs[i].eoi_v;
      OCW2 = vecs[i].ocw2;
      step();
      check_all($sformatf("row%0d", i), vecs[i].exp);
    end
    eoi_valid = 1'b0;
    AEOI = 1'b0;

    // Build ISR = 8'h24, then non-specific and specific EOI
    run_ack(3'd2);
    run_ack(3'd5);
    check8("isr_24", ISR_reg, 8'h24);
    check8("vec_5", data_out, 8'h8D);
    zeroLevelPriorityBit = 3'd3;
    do_eoi(8'h20);
    check8("ns_eoi_isr", ISR_reg, 8'h04);
    check8("ns_eoi_idx", {5'd0, resetedISR_index}, 8'd5);
    do_eoi(8'h62);
    check8("sp_eoi_isr", ISR_reg, 8'h00);
    check8("sp_eoi_idx", {5'd0, resetedISR_index}, 8'd2);
    do_eoi(8'h20);
    check8("ns_empty_isr", ISR_reg, 8'h00);
    check8("ns_empty_idx", {5'd0, resetedISR_index}, 8'd2);

    // Specific EOI of bit 4 on the same edge that sets bit 4
    INT_request = 1'b1;
    serviced_interrupt_index = 3'd4;
    step();
    INT_request = 1'b0;
    check8("int_up", {7'd0, INT}, 8'd1);
    INTA_n = 1'b0;
    step();
    step();
    OCW2 = 8'h64;
    eoi_valid = 1'b1;
    step();
    eoi_valid = 1'b0;
    check8("set_wins_isr", ISR_reg, 8'h10);
    check8("set_wins_idx", {5'd0, resetedISR_index}, 8'd2);
    check8("irr_clr4", {4'd0, IRR_clear, IRR_clear_index}, 8'h0C);

    // Reset while waiting in GAP, then an ignored INTA pulse pair
    INTA_n = 1'b1;
    repeat (3) step();
    INTA_n = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all("reset_gap", '0);
    for (int p = 0; p < 4; p++) begin
      INTA_n = (p % 2 == 1);
      for (int k = 0; k < 3; k++) begin
        step();
        check_all($sformatf("idle_inta_%0d_%0d", p, k), '0);
      end
    end

    // Non-specific scan wrapping past bit 7
    run_ack(3'd6);
    run_ack(3'd1);
    check8("isr_42", ISR_reg, 8'h42);
    zeroLevelPriorityBit = 3'd7;
    do_eoi(8'h20);
    check8("wrap_isr", ISR_reg, 8'h40);
    check8("wrap_idx", {5'd0, resetedISR_index}, 8'd1);
    do_eoi(8'h40);
    check8("nop_cmd_isr", ISR_reg, 8'h40);
    check8("nop_cmd_idx", {5'd0, resetedISR_index}, 8'd1);
    do_eoi(8'hA0);
    check8("ns101_isr", ISR_reg, 8'h00);
    check8("ns101_idx", {5'd0, resetedISR_index}, 8'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
